dco_word_ramp: RTL and testbench

- Sequencer for the 5x5 DCO row/column coder.
- Accepts a requested tuning word and slews the coder's word input one LSB per pacing tick, so no multi-cell capacitor switching happens in one update.
- Drives the coder's en strobe, then waits a programmable settle time before acknowledging completion.
- Sits between the ADPLL loop/calibration logic and the coder input.

---
 rtl/dco_word_ramp.sv | 181 ++++++++++++++++++
 tb/tb_dco_word_ramp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dco_word_ramp.sv
// rtl/dco_word_ramp.sv - one-LSB-per-tick word slew sequencer for the 5x5 DCO coder (optional: DCO_RAMP_DITHER_EN)
module dco_word_ramp #(
  parameter int MAX        = 25,
  parameter int WIDTH      = 5,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tick,
  input  logic             abort,
  input  logic             frac,
  output logic [WIDTH-1:0] word,
  output logic             word_en,
  output logic             busy,
  output logic             ack,
  output logic             clamped
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [CNT_W-1:0] SETTLE_W = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] tgt_q_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] tgt_sat;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] word_ref;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clamped_nxt;
  logic             changed;

`ifdef DCO_RAMP_DITHER_EN
  // base is the word the dither toggles around: the last settled (or aborted-at) word
  logic [WIDTH-1:0] base;
  assign word_ref = base;
`else
  logic             unused_frac;
  assign unused_frac = frac;
  assign word_ref    = word;
`endif

  // Requests above the top legal code are pinned to MAX
  assign tgt_sat = (tgt > MAX_W) ? MAX_W : tgt;

  // One LSB toward the latched target; only consumed in RAMP where word != tgt_q, so no wrap
  assign step = (word < tgt_q) ? (word + ONE_W) : (word - ONE_W);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort beats a same-cycle tick
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (tgt_sat != word_ref) ? RAMP : DONE;
        end
      end
      RAMP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tick && (step == tgt_q)) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next values of the datapath registers for the current state
  always_comb begin
    word_nxt    = word;
    tgt_q_nxt   = tgt_q;
    clamped_nxt = clamped;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          tgt_q_nxt   = tgt_sat;
          clamped_nxt = (tgt > MAX_W);
          word_nxt    = word_ref;
        end
`ifdef DCO_RAMP_DITHER_EN
        else if (tick) begin
          if (frac && (word == base) && (base != MAX_W)) begin
            word_nxt = base + ONE_W;
          end else begin
            word_nxt = base;
          end
        end
`endif
      end
      RAMP: begin
        if (!abort && tick) begin
          word_nxt = step;
          if (step == tgt_q) begin
            cnt_nxt = SETTLE_W;
          end
        end
      end
      SETTLE: begin
        if (!abort && (cnt != '0)) begin
          cnt_nxt = cnt - ONE_C;
        end
      end
      default: begin
        cnt_nxt = cnt;
      end
    endcase
  end

  // Datapath and output registers; word_en trails a word change by one cycle for the coder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      tgt_q   <= '0;
      clamped <= 1'b0;
      cnt     <= '0;
      changed <= 1'b0;
      word_en <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
    end else begin
      word    <= word_nxt;
      tgt_q   <= tgt_q_nxt;
      clamped <= clamped_nxt;
      cnt     <= cnt_nxt;
      changed <= (word_nxt != word);
      word_en <= changed;
      busy    <= (state_nxt != IDLE);
      ack     <= (state_nxt == DONE);
    end
  end

`ifdef DCO_RAMP_DITHER_EN
  // Capture the resting word whenever the sequencer drops back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
    end else if ((state != IDLE) && (state_nxt == IDLE)) begin
      base <= word;
    end
  end
`endif

endmodule

// File: tb/tb_dco_word_ramp.sv
// tb/tb_dco_word_ramp.sv - randomized self-checking bench for dco_word_ramp
module tb_dco_word_ramp;

  localparam int MAXV   = 25;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [4:0] tgt;
  logic       tick;
  logic       abort;
  logic       frac;
  logic [4:0] word;
  logic       word_en;
  logic       busy;
  logic       ack;
  logic       clamped;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         mw    = 0;

  dco_word_ramp #(
    .MAX(MAXV), .WIDTH(5), .SETTLE_CYC(SETTLE), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .tgt(tgt), .tick(tick), .abort(abort),
    .frac(frac), .word(word), .word_en(word_en), .busy(busy), .ack(ack),
    .clamped(clamped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Move from the model word mw to target t. Expectations come from counting ticks:
  // word = start + dir*min(ticks,dist); ack lands SETTLE+1 edges after the last step.
  task automatic run_move(input int t, input int mode, input string tag);
    int tc, d, sgn, ticks, ack_edge, c, ew, wh1, wh2;
    logic tk, een, ebusy, eack;
    tc = (t > MAXV) ? MAXV : t;
    d = (tc > mw) ? tc - mw : mw - tc;
    sgn = (tc > mw) ? 1 : -1;
    ticks = 0;
    ack_edge = (d == 0) ? 0 : -1;
    wh1 = mw;
    wh2 = mw;
    ew = mw;
    req = 1'b1; tgt = 5'(t); tick = 1'($urandom_range(0, 1)); abort = 1'b0; frac = 1'b0;
    c = 0;
    while (1) begin
      @(posedge clk); #1;
      ew = mw + sgn * ticks;
      een = (wh1 != wh2);
      ebusy = (ack_edge < 0) || (c <= ack_edge);
      eack = (c == ack_edge);
      n_cmp++;
      if (int'(word) !== ew) begin
        n_bad++; $display("FAIL %s word c=%0d got %0d want %0d", tag, c, word, ew);
      end
      n_cmp++;
      if (word_en !== een) begin
        n_bad++; $display("FAIL %s word_en c=%0d got %0b want %0b", tag, c, word_en, een);
      end
      n_cmp++;
      if (busy !== ebusy) begin
        n_bad++; $display("FAIL %s busy c=%0d got %0b want %0b", tag, c, busy, ebusy);
      end
      n_cmp++;
      if (ack !== eack) begin
        n_bad++; $display("FAIL %s ack c=%0d got %0b want %0b", tag, c, ack, eack);
      end
      n_cmp++;
      if (clamped !== (t > MAXV)) begin
        n_bad++; $display("FAIL %s clamped c=%0d got %0b want %0b", tag, c, clamped, (t > MAXV));
      end
      wh2 = wh1;
      wh1 = ew;
      if (ack_edge >= 0 && c == ack_edge + 1) break;
      if (c > 400) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout got no ack want ack", tag);
        break;
      end
      case (mode)
        0: tk = 1'b1;
        1: tk = ((c + 1) % 3 == 0);
        default: tk = 1'($urandom_range(0, 1));
      endcase
      tick = tk;
      if (ack_edge < 0 && tk) begin
        ticks++;
        if (ticks == d) ack_edge = c + 1 + SETTLE + 1;
      end
      req = (ack_edge < 0 || c <= ack_edge) ? 1'($urandom_range(0, 1)) : 1'b0;
      tgt = 5'($urandom_range(0, 31));
      c++;
    end
    req = 1'b0;
    mw = ew;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; tgt = 5'd0; tick = 1'b0; abort = 1'b0; frac = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (word !== 5'd0) begin n_bad++; $display("FAIL reset word got %0d want 0", word); end
    n_cmp++; if (word_en !== 1'b0) begin n_bad++; $display("FAIL reset word_en got %0b want 0", word_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %0b want 0", busy); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset ack got %0b want 0", ack); end
    n_cmp++; if (clamped !== 1'b0) begin n_bad++; $display("FAIL reset clamped got %0b want 0", clamped); end
    rst = 1'b0;
    mw = 0;
  endtask

  task automatic test_reset_mid();
    req = 1'b1; tgt = 5'd30; tick = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (int'(word) !== mw + 2) begin n_bad++; $display("FAIL midrst pre word got %0d want %0d", word, mw + 2); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (word !== 5'd0) begin n_bad++; $display("FAIL midrst word got %0d want 0", word); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst busy got %0b want 0", busy); end
    n_cmp++; if (clamped !== 1'b0) begin n_bad++; $display("FAIL midrst clamped got %0b want 0", clamped); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (SETTLE + 3) begin
      @(posedge clk); #1;
      n_cmp++; if (ack !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst idle ack/busy got %0b/%0b want 0/0", ack, busy); end
    end
    mw = 0;
  endtask

  task automatic test_abort();
    req = 1'b1; tgt = 5'd10; tick = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    tgt = 5'd20;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if (word !== 5'd4) begin n_bad++; $display("FAIL abort pre word got %0d want 4", word); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; req = 1'b0;
    n_cmp++; if (word !== 5'd4) begin n_bad++; $display("FAIL abort word got %0d want 4", word); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort busy got %0b want 0", busy); end
    repeat (SETTLE + 3) begin
      @(posedge clk); #1;
      n_cmp++; if (ack !== 1'b0 || word !== 5'd4) begin n_bad++; $display("FAIL abort after ack/word got %0b/%0d want 0/4", ack, word); end
    end
    mw = 4;
    run_move(10, 0, "reramp");
    req = 1'b1; tgt = 5'd13; tick = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (word !== 5'd13 || busy !== 1'b0) begin n_bad++; $display("FAIL settle abort word/busy got %0d/%0b want 13/0", word, busy); end
    repeat (SETTLE + 3) begin
      @(posedge clk); #1;
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL settle abort ack got %0b want 0", ack); end
    end
    mw = 13;
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      run_move(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

`ifdef DCO_RAMP_DITHER_EN
  task automatic test_dither();
    int n;
    run_move(12, 0, "dbase");
    frac = 1'b1; tick = 1'b1; req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (int'(word) !== ((k % 2 == 0) ? 13 : 12)) begin n_bad++; $display("FAIL dither word k=%0d got %0d", k, word); end
    end
    req = 1'b1; tgt = 5'd14;
    @(posedge clk); #1;
    req = 1'b0; frac = 1'b0;
    n_cmp++; if (word !== 5'd12) begin n_bad++; $display("FAIL dither restore got %0d want 12", word); end
    @(posedge clk); #1;
    n_cmp++; if (word !== 5'd13) begin n_bad++; $display("FAIL dither step1 got %0d want 13", word); end
    @(posedge clk); #1;
    n_cmp++; if (word !== 5'd14) begin n_bad++; $display("FAIL dither step2 got %0d want 14", word); end
    n = 0;
    while (ack !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL dither ack timeout got 0 want 1"); end
    @(posedge clk); #1;
    mw = 14;
    run_move(25, 0, "dmax");
    frac = 1'b1; tick = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++; if (word !== 5'd25) begin n_bad++; $display("FAIL dither max got %0d want 25", word); end
    end
    frac = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    run_move(7, 0, "basic");
    run_move(30, 0, "clamp_up");
    run_move(3, 0, "clamp_down");
    run_move(mw + 2, 1, "sparse");
    run_move(mw, 0, "same");
    test_reset_mid();
    test_abort();
    test_random();
`ifdef DCO_RAMP_DITHER_EN
    test_dither();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
